// File: rtl/etc_tile_sched.sv
// Job scheduler for a 4x4 extended tensor core tile: walks M x N x K, tags beats, accumulates over K, queues C tiles.
// Optional performance counters are enabled with `define ETC_SCHED_PERF_EN.
module etc_tile_sched #(
  parameter int W         = 16,
  parameter int TW        = 4,
  parameter int CORE_LAT  = 3,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [TW-1:0]     m_tiles,
  input  logic [TW-1:0]     n_tiles,
  input  logic [TW-1:0]     k_tiles,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [2*TW-1:0]   a_idx,
  output logic [2*TW-1:0]   b_idx,
  output logic [1:0]        core_op,
  input  logic [16*W-1:0]   core_out,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [16*W-1:0]   o_data,
  output logic [TW-1:0]     o_m,
  output logic [TW-1:0]     o_n
`ifdef ETC_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_busy_cyc,
  output logic [31:0]       perf_stall_cyc
`endif
);

  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int DW = 16 * W;
  localparam int EW = DW + 2 * TW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [TW-1:0]  m_dim, n_dim, k_dim;
  logic [TW-1:0]  m_cnt, n_cnt, k_cnt;
  logic [1:0]     op_r;
  logic [CW-1:0]  credits;
  logic           done_r;

  logic           tag_v     [CORE_LAT];
  logic           tag_first [CORE_LAT];
  logic           tag_last  [CORE_LAT];
  logic [TW-1:0]  tag_m     [CORE_LAT];
  logic [TW-1:0]  tag_n     [CORE_LAT];

  logic [DW-1:0]  acc, acc_nx;
  logic [EW-1:0]  mem [OUT_DEPTH];
  logic [AW:0]    wptr, rptr;
  logic [EW-1:0]  head;

  logic start_ok, dims_ok;
  logic k_last, n_last, m_last;
  logic issue, issue_last, final_beat;
  logic tags_busy, fifo_empty, pop, push, drain_done;
  logic exit_v, exit_first, exit_last;
  logic [TW-1:0] exit_m, exit_n;
  logic [2*TW-1:0] m_w, n_w, k_w, kd_w, nd_w;

  assign start_ok   = start && (state == S_IDLE);
  assign dims_ok    = (m_tiles != '0) && (n_tiles != '0) && (k_tiles != '0);
  assign k_last     = (k_cnt == k_dim - TW'(1));
  assign n_last     = (n_cnt == n_dim - TW'(1));
  assign m_last     = (m_cnt == m_dim - TW'(1));
  // Only the beat that completes a tile needs an output slot reserved.
  assign issue      = (state == S_ISSUE) && (!k_last || (credits != '0));
  assign issue_last = issue && k_last;
  assign final_beat = issue_last && n_last && m_last;

  assign exit_v     = tag_v[CORE_LAT-1];
  assign exit_first = tag_first[CORE_LAT-1];
  assign exit_last  = tag_last[CORE_LAT-1];
  assign exit_m     = tag_m[CORE_LAT-1];
  assign exit_n     = tag_n[CORE_LAT-1];

  assign fifo_empty = (wptr == rptr);
  assign pop        = !fifo_empty && o_ready;
  assign push       = exit_v && exit_last;
  assign drain_done = (state == S_DRAIN) && !tags_busy && fifo_empty;

  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i < CORE_LAT; i++) tags_busy = tags_busy | tag_v[i];
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_ok && dims_ok) state_nx = S_ISSUE;
      S_ISSUE: if (final_beat) state_nx = S_DRAIN;
      S_DRAIN: if (drain_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_dim   <= '0;
      n_dim   <= '0;
      k_dim   <= '0;
      m_cnt   <= '0;
      n_cnt   <= '0;
      k_cnt   <= '0;
      op_r    <= '0;
      done_r  <= 1'b0;
      credits <= CW'(OUT_DEPTH);
    end else begin
      done_r  <= (start_ok && !dims_ok) || drain_done;
      credits <= credits + CW'(pop) - CW'(issue_last);
      if (start_ok && dims_ok) begin
        m_dim <= m_tiles;
        n_dim <= n_tiles;
        k_dim <= k_tiles;
        op_r  <= op;
        m_cnt <= '0;
        n_cnt <= '0;
        k_cnt <= '0;
      end else if (issue) begin
        // Counters wrap to zero on the final beat, leaving indices at 0 between jobs.
        if (k_last) begin
          k_cnt <= '0;
          if (n_last) begin
            n_cnt <= '0;
            m_cnt <= m_last ? '0 : m_cnt + TW'(1);
          end else begin
            n_cnt <= n_cnt + TW'(1);
          end
        end else begin
          k_cnt <= k_cnt + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CORE_LAT; i++) begin
        tag_v[i]     <= 1'b0;
        tag_first[i] <= 1'b0;
        tag_last[i]  <= 1'b0;
        tag_m[i]     <= '0;
        tag_n[i]     <= '0;
      end
    end else begin
      tag_v[0]     <= issue;
      tag_first[0] <= (k_cnt == '0);
      tag_last[0]  <= k_last;
      tag_m[0]     <= m_cnt;
      tag_n[0]     <= n_cnt;
      for (int i = 1; i < CORE_LAT; i++) begin
        tag_v[i]     <= tag_v[i-1];
        tag_first[i] <= tag_first[i-1];
        tag_last[i]  <= tag_last[i-1];
        tag_m[i]     <= tag_m[i-1];
        tag_n[i]     <= tag_n[i-1];
      end
    end
  end

  always_comb begin
    acc_nx = '0;
    for (int e = 0; e < 16; e++) begin
      if (exit_first) acc_nx[e*W +: W] = core_out[e*W +: W];
      else            acc_nx[e*W +: W] = acc[e*W +: W] + core_out[e*W +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= '0;
    else if (exit_v) acc <= acc_nx;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= {acc_nx, exit_m, exit_n};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  assign m_w  = {{TW{1'b0}}, m_cnt};
  assign n_w  = {{TW{1'b0}}, n_cnt};
  assign k_w  = {{TW{1'b0}}, k_cnt};
  assign kd_w = {{TW{1'b0}}, k_dim};
  assign nd_w = {{TW{1'b0}}, n_dim};

  assign busy    = (state != S_IDLE);
  assign done    = done_r;
  assign rd_en   = issue;
  assign a_idx   = m_w * kd_w + k_w;
  assign b_idx   = k_w * nd_w + n_w;
  assign core_op = op_r;

  // Head is gated so the outputs read zero whenever the queue is empty.
  assign head    = mem[rptr[AW-1:0]];
  assign o_valid = !fifo_empty;
  assign o_data  = o_valid ? head[EW-1 -: DW] : '0;
  assign o_m     = o_valid ? head[2*TW-1:TW]  : '0;
  assign o_n     = o_valid ? head[TW-1:0]     : '0;

`ifdef ETC_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (start_ok) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (busy && (perf_busy_cyc != '1)) perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if ((state == S_ISSUE) && !issue && (perf_stall_cyc != '1))
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_etc_tile_sched.sv
// Self-checking bench for etc_tile_sched: a behavioural core model feeds core_out, a scoreboard checks beats and tiles.
module tb_etc_tile_sched;

  localparam int W         = 16;
  localparam int TW        = 4;
  localparam int CORE_LAT  = 3;
  localparam int OUT_DEPTH = 4;
  localparam int DW        = 16 * W;
  localparam int IW        = 2 * TW;
  localparam int EW        = DW + 2 * TW;

  logic            clk, rst, start, o_ready, busy, done, rd_en, o_valid;
  logic [1:0]      op, core_op;
  logic [TW-1:0]   m_tiles, n_tiles, k_tiles, o_m, o_n;
  logic [IW-1:0]   a_idx, b_idx;
  logic [DW-1:0]   core_out, o_data;
`ifdef ETC_SCHED_PERF_EN
  logic [31:0]     perf_busy_cyc, perf_stall_cyc;
`endif

  etc_tile_sched #(.W(W), .TW(TW), .CORE_LAT(CORE_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .m_tiles(m_tiles), .n_tiles(n_tiles), .k_tiles(k_tiles),
    .busy(busy), .done(done), .rd_en(rd_en), .a_idx(a_idx), .b_idx(b_idx),
    .core_op(core_op), .core_out(core_out),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_m(o_m), .o_n(o_n)
`ifdef ETC_SCHED_PERF_EN
    , .perf_busy_cyc(perf_busy_cyc), .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]   exp_q[$];
  logic [2*IW-1:0] idx_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, rd_cnt = 0, tile_cnt = 0, rd_cyc = 0, ov_first = -1;
  logic [1:0]      job_op = '0;
  logic [DW-1:0]   last_tile = '0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- core model ----------------
  int core_beat = 0;
  int c_base = 0, c_inc = 0, c_step = 0;
  logic [DW-1:0] core_pipe [CORE_LAT] = '{default: '0};

  function automatic logic [DW-1:0] beat_data(input int b);
    logic [DW-1:0] d;
    for (int e = 0; e < 16; e++) d[e*W +: W] = W'(c_base + b * c_inc + e * c_step);
    return d;
  endfunction

  // Idle slots carry all-ones junk so any untagged capture shows up.
  always @(negedge clk) begin
    core_out = core_pipe[CORE_LAT-1];
    for (int i = CORE_LAT - 1; i > 0; i--) core_pipe[i] = core_pipe[i-1];
    if (rd_en) begin
      core_pipe[0] = beat_data(core_beat);
      core_beat++;
    end else begin
      core_pipe[0] = '1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [2*IW-1:0] ie;
    logic [EW-1:0]   te;
    #1;
    cyc++;
    if (!rst) begin
      if (rd_en) begin
        rd_cnt++;
        rd_cyc = cyc;
        check("core_op", EW'(core_op), EW'(job_op));
        if (idx_q.size() == 0) check("spurious_rd_en", EW'(rd_en), EW'(0));
        else begin
          ie = idx_q.pop_front();
          check("rd_idx", EW'({a_idx, b_idx}), EW'(ie));
        end
      end
      if (o_valid && ov_first < 0) ov_first = cyc;
      if (o_valid && o_ready) begin
        tile_cnt++;
        last_tile = o_data;
        if (exp_q.size() == 0) check("spurious_tile", EW'(o_valid), EW'(0));
        else begin
          te = exp_q.pop_front();
          check("tile", {o_data, o_m, o_n}, te);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic prep_job(input int m, input int n, input int k, input int oo,
                          input int base, input int inc, input int step);
    logic [DW-1:0] acc, d;
    c_base = base; c_inc = inc; c_step = step;
    core_beat = 0; job_op = 2'(oo);
    rd_cnt = 0; tile_cnt = 0; ov_first = -1; rd_cyc = 0;
    for (int mi = 0; mi < m; mi++)
      for (int ni = 0; ni < n; ni++) begin
        acc = '0;
        for (int ki = 0; ki < k; ki++) begin
          d = beat_data((mi * n + ni) * k + ki);
          for (int e = 0; e < 16; e++) acc[e*W +: W] = acc[e*W +: W] + d[e*W +: W];
          idx_q.push_back({IW'(mi * k + ki), IW'(ki * n + ni)});
        end
        exp_q.push_back({acc, TW'(mi), TW'(ni)});
      end
  endtask

  task automatic pulse_start(input int m, input int n, input int k, input int oo);
    @(negedge clk);
    start = 1'b1; op = 2'(oo);
    m_tiles = TW'(m); n_tiles = TW'(n); k_tiles = TW'(k);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit rnd, input int exp_rd);
    bit got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    o_ready = 1'b1;
    check("done_seen", EW'(got), EW'(1));
    check("busy_at_done", EW'(busy), EW'(0));
    check("tiles_left", EW'(exp_q.size()), EW'(0));
    check("beats_left", EW'(idx_q.size()), EW'(0));
    check("rd_count", EW'(rd_cnt), EW'(exp_rd));
    @(negedge clk);
    check("done_width", EW'(done), EW'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},    EW'(busy),    EW'(0));
    check({tag, "_done"},    EW'(done),    EW'(0));
    check({tag, "_rd_en"},   EW'(rd_en),   EW'(0));
    check({tag, "_o_valid"}, EW'(o_valid), EW'(0));
    check({tag, "_idx"},     EW'({a_idx, b_idx}), EW'(0));
    check({tag, "_core_op"}, EW'(core_op), EW'(0));
    check({tag, "_out"},     {o_data, o_m, o_n}, EW'(0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int m, n, k, op, base, inc, step;
    bit rnd;
    int exp_rd, exp_tiles, exp_fill;
  } job_t;

  job_t tab[8];

  initial begin
    logic [DW-1:0] fill;
    tab[0] = '{1, 1, 1, 0, 2,       0,       0,       1'b0, 1,  1, 2};
    tab[1] = '{1, 1, 3, 0, 5,       0,       0,       1'b0, 3,  1, 15};
    tab[2] = '{1, 1, 2, 1, 'hFFFF,  3,       0,       1'b0, 2,  1, 1};
    tab[3] = '{2, 3, 2, 0, 'h10,    7,       1,       1'b1, 12, 6, -1};
    tab[4] = '{3, 2, 1, 2, 'h100,   1,       3,       1'b1, 6,  6, -1};
    tab[5] = '{1, 2, 4, 1, 'hFFF0,  5,       'h1111,  1'b0, 8,  2, -1};
    tab[6] = '{4, 1, 3, 3, 'h7FFF,  'h4001,  2,       1'b1, 12, 4, -1};
    tab[7] = '{2, 2, 2, 0, 1,       1,       1,       1'b1, 8,  4, -1};

    rst = 1'b1; start = 1'b0; op = '0; o_ready = 1'b1;
    m_tiles = '0; n_tiles = '0; k_tiles = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      prep_job(tab[t].m, tab[t].n, tab[t].k, tab[t].op, tab[t].base, tab[t].inc, tab[t].step);
      pulse_start(tab[t].m, tab[t].n, tab[t].k, tab[t].op);
      check("busy_after_start", EW'(busy), EW'(1));
      wait_done(tab[t].rnd, tab[t].exp_rd);
      check("tile_count", EW'(tile_cnt), EW'(tab[t].exp_tiles));
      if (tab[t].exp_fill >= 0) begin
        for (int e = 0; e < 16; e++) fill[e*W +: W] = W'(tab[t].exp_fill);
        check("tile_fill", EW'(last_tile), EW'(fill));
      end
      if (tab[t].exp_rd == 1) check("o_valid_latency", EW'(ov_first - rd_cyc), EW'(CORE_LAT + 1));
    end

    // 2x2x1 with the consumer blocked: all four tiles fit, then the queue holds.
    o_ready = 1'b0;
    prep_job(2, 2, 1, 0, 'h40, 9, 2);
    pulse_start(2, 2, 1, 0);
    o_ready = 1'b0;
    repeat (20) @(negedge clk);
    check("hold4_rd_count", EW'(rd_cnt), EW'(4));
    check("hold4_o_valid", EW'(o_valid), EW'(1));
    check("hold4_busy", EW'(busy), EW'(1));
    check("hold4_head", {o_data, o_m, o_n}, exp_q[0]);
    repeat (3) @(negedge clk);
    check("hold4_head_stable", {o_data, o_m, o_n}, exp_q[0]);
    wait_done(1'b0, 4);
    check("hold4_tiles", EW'(tile_cnt), EW'(4));

    // 3x2x2 blocked: eight beats fill four credits, one more non-last beat slips out.
    o_ready = 1'b0;
    prep_job(3, 2, 2, 2, 'h1234, 'h111, 1);
    pulse_start(3, 2, 2, 2);
    o_ready = 1'b0;
    repeat (30) @(negedge clk);
    check("credit_rd_count", EW'(rd_cnt), EW'(9));
    check("credit_busy", EW'(busy), EW'(1));
`ifdef ETC_SCHED_PERF_EN
    check("perf_stall_nonzero", EW'(perf_stall_cyc != 0), EW'(1));
`endif
    wait_done(1'b0, 12);
    check("credit_tiles", EW'(tile_cnt), EW'(6));

    // Zero dimension: immediate done, nothing issued.
    rd_cnt = 0;
    pulse_start(0, 3, 3, 0);
    check("zero_done", EW'(done), EW'(1));
    check("zero_busy", EW'(busy), EW'(0));
    @(negedge clk);
    check("zero_done_width", EW'(done), EW'(0));
    repeat (5) @(negedge clk);
    check("zero_rd_count", EW'(rd_cnt), EW'(0));
    check("zero_busy_after", EW'(busy), EW'(0));

    // Reset in the middle of a 2x2x2 job, then a clean 1x1x1 job.
    o_ready = 1'b1;
    prep_job(2, 2, 2, 2, 9, 1, 0);
    pulse_start(2, 2, 2, 2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    idx_q.delete();
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_no_tile", EW'(o_valid), EW'(0));
    check("post_rst_idle", EW'(busy), EW'(0));
    prep_job(1, 1, 1, 0, 'h33, 0, 1);
    pulse_start(1, 1, 1, 0);
    wait_done(1'b0, 1);
    check("post_rst_tiles", EW'(tile_cnt), EW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
